// File: rtl/signed_mac_pipe.sv
// signed_mac_pipe: pipelined multiply-accumulate unit with valid/ready
// handshakes. Each operand set carries its own signedness and
// accumulate/load control. A single advance enable freezes the whole pipe
// whenever a result is held at the output and is not being consumed.
// The first register stage holds the extended operands. Optional middle
// stages carry the product. The last stage is the accumulator together with
// the registered result.
module signed_mac_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    input  logic                 acc_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int PW  = 2 * WIDTH;
    localparam int MID = STAGES - 2;

    logic                    adv_s;
    logic signed [WIDTH:0]   ext_a_s;
    logic signed [WIDTH:0]   ext_b_s;

    logic                    s1_v_r;
    logic signed [WIDTH:0]   s1_a_r;
    logic signed [WIDTH:0]   s1_b_r;
    logic                    s1_acc_en_r;

    logic signed [PW-1:0]    wide_a_s;
    logic signed [PW-1:0]    wide_b_s;
    logic signed [PW-1:0]    prod_s;

    logic                    fin_v_s;
    logic [PW-1:0]           fin_prod_s;
    logic                    fin_acc_en_s;
    logic                    mid_any_s;

    logic [PW-1:0]           acc_r;
    logic [PW-1:0]           acc_next_s;

    // The whole pipe moves only when the output slot is empty or being drained
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // Widen operands by one bit so a single signed multiply covers both modes
    always_comb begin
        ext_a_s = '0;
        ext_b_s = '0;
        if (sgn) begin
            ext_a_s = {a[WIDTH-1], a};
            ext_b_s = {b[WIDTH-1], b};
        end else begin
            ext_a_s = {1'b0, a};
            ext_b_s = {1'b0, b};
        end
    end

    // Stage 1: capture the extended operands and their control bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_r      <= 1'b0;
            s1_a_r      <= '0;
            s1_b_r      <= '0;
            s1_acc_en_r <= 1'b0;
        end else if (adv_s) begin
            s1_v_r      <= in_valid;
            s1_a_r      <= ext_a_s;
            s1_b_r      <= ext_b_s;
            s1_acc_en_r <= acc_en;
        end
    end

    // The low PW bits of the extended product are exact in both modes
    assign wide_a_s = PW'(s1_a_r);
    assign wide_b_s = PW'(s1_b_r);
    assign prod_s   = wide_a_s * wide_b_s;

    generate
        if (STAGES == 2) begin : g_no_mid
            assign fin_v_s      = s1_v_r;
            assign fin_prod_s   = prod_s;
            assign fin_acc_en_s = s1_acc_en_r;
            assign mid_any_s    = 1'b0;
        end else begin : g_mid
            logic [MID-1:0] mid_v_r;
            logic [MID-1:0] mid_acc_en_r;
            logic [PW-1:0]  mid_prod_r [MID];

            // Middle stages: register the product, then carry it toward the accumulator
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mid_v_r      <= '0;
                    mid_acc_en_r <= '0;
                    for (int i = 0; i < MID; i++) begin
                        mid_prod_r[i] <= '0;
                    end
                end else if (adv_s) begin
                    mid_v_r[0]      <= s1_v_r;
                    mid_acc_en_r[0] <= s1_acc_en_r;
                    mid_prod_r[0]   <= prod_s;
                    for (int i = 1; i < MID; i++) begin
                        mid_v_r[i]      <= mid_v_r[i-1];
                        mid_acc_en_r[i] <= mid_acc_en_r[i-1];
                        mid_prod_r[i]   <= mid_prod_r[i-1];
                    end
                end
            end

            assign fin_v_s      = mid_v_r[MID-1];
            assign fin_prod_s   = mid_prod_r[MID-1];
            assign fin_acc_en_s = mid_acc_en_r[MID-1];
            assign mid_any_s    = |mid_v_r;
        end
    endgenerate

    // Accumulate or load; wraps modulo 2^PW without saturation
    always_comb begin
        acc_next_s = fin_prod_s;
        if (fin_acc_en_s) begin
            acc_next_s = acc_r + fin_prod_s;
        end else begin
            acc_next_s = fin_prod_s;
        end
    end

    // Final stage: bubbles pass through without touching the accumulator or result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            acc_r     <= '0;
            out       <= '0;
        end else if (adv_s) begin
            out_valid <= fin_v_s;
            if (fin_v_s) begin
                acc_r <= acc_next_s;
                out   <= acc_next_s;
            end
        end
    end

    assign busy = s1_v_r || mid_any_s || out_valid;

endmodule

// File: tb/tb_signed_mac_pipe.sv
// Bench for signed_mac_pipe (WIDTH=16, STAGES=3): directed vectors with
// literal expectations, plus a queue model that computes every result
// arithmetically in acceptance order and is compared against the DUT on
// every cycle.
module tb_signed_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        acc_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit [31:0] exp_q[$];
    bit [31:0] log_val[$];
    int        log_cyc[$];
    bit [31:0] m_acc = 32'd0;
    bit [31:0] nxt;

    signed_mac_pipe #(.WIDTH(16), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .acc_en(acc_en), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Exact product of the operands as integers, then wrap into 32 bits.
    function automatic bit [31:0] mac(input bit [15:0] x, input bit [15:0] y,
                                      input bit s, input bit e, input bit [31:0] acc);
        longint px;
        longint py;
        longint p;
        bit [31:0] p32;
        px  = s ? longint'($signed(x)) : longint'(x);
        py  = s ? longint'($signed(y)) : longint'(y);
        p   = px * py;
        p32 = p[31:0];
        return e ? (acc + p32) : p32;
    endfunction

    // Model: record accepted operations and consumed results in order.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_acc <= 32'd0;
        end else begin
            if (out_valid && out_ready) begin
                log_val.push_back(out);
                log_cyc.push_back(cyc);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                nxt = mac(a, b, sgn, acc_en, m_acc);
                m_acc <= nxt;
                exp_q.push_back(nxt);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            chk("busy", {31'd0, busy}, {31'd0, (exp_q.size() != 0)});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got 0x%08h expected no result", out);
                end else begin
                    chk("out_model", out, exp_q[0]);
                end
            end
        end
    end

    task automatic op(input bit [15:0] x, input bit [15:0] y, input bit s, input bit e);
        int n;
        n = 0;
        a = x; b = y; sgn = s; acc_en = e; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", {31'd0, (n < 100)}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'd0; b = 16'd0; sgn = 1'b0; acc_en = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency and most-negative square
        op(16'h8000, 16'h8000, 1'b1, 1'b0);
        chk("lat_edge0", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_edge1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", {31'd0, out_valid}, 32'd1);
        chk("min_square", out, 32'h40000000);
        drain();

        // Signed vs unsigned interpretation
        log_val.delete(); log_cyc.delete();
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drain();
        chk("sgn_count", log_val.size(), 32'd2);
        if (log_val.size() == 2) begin
            chk("unsigned_ffff", log_val[0], 32'hFFFE0001);
            chk("signed_ffff", log_val[1], 32'h00000001);
        end

        // Back-to-back accumulation
        log_val.delete(); log_cyc.delete();
        op(16'd3, 16'hFFFC, 1'b1, 1'b0);
        op(16'd5, 16'd6, 1'b1, 1'b1);
        op(16'hFFFE, 16'd7, 1'b1, 1'b1);
        drain();
        chk("b2b_count", log_val.size(), 32'd3);
        if (log_val.size() == 3) begin
            chk("b2b_0", log_val[0], 32'hFFFFFFF4);
            chk("b2b_1", log_val[1], 32'h00000012);
            chk("b2b_2", log_val[2], 32'h00000004);
            chk("b2b_gap01", log_cyc[1] - log_cyc[0], 32'd1);
            chk("b2b_gap12", log_cyc[2] - log_cyc[1], 32'd1);
        end

        // Unsigned wraparound
        log_val.delete(); log_cyc.delete();
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        drain();
        chk("wrap_count", log_val.size(), 32'd2);
        if (log_val.size() == 2) begin
            chk("wrap_load", log_val[0], 32'hFFFE0001);
            chk("wrap_acc", log_val[1], 32'hFFFC0002);
        end

        // Backpressure with a full pipeline
        log_val.delete(); log_cyc.delete();
        out_ready = 1'b0;
        op(16'd1, 16'd1, 1'b1, 1'b0);
        op(16'd2, 16'd2, 1'b1, 1'b1);
        op(16'd3, 16'd3, 1'b1, 1'b1);
        a = 16'd4; b = 16'd4; sgn = 1'b1; acc_en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out", out, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        chk("stall_count", log_val.size(), 32'd4);
        if (log_val.size() == 4) begin
            chk("drain_0", log_val[0], 32'd1);
            chk("drain_1", log_val[1], 32'd5);
            chk("drain_2", log_val[2], 32'd14);
            chk("drain_3", log_val[3], 32'd30);
            chk("drain_gap01", log_cyc[1] - log_cyc[0], 32'd1);
            chk("drain_gap12", log_cyc[2] - log_cyc[1], 32'd1);
        end

        // Reset with two operations in flight
        log_val.delete(); log_cyc.delete();
        op(16'd7, 16'd7, 1'b1, 1'b0);
        op(16'd8, 16'd8, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out", out, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_ghost", log_val.size(), 32'd0);
        op(16'd2, 16'd3, 1'b1, 1'b1);
        drain();
        chk("post_rst_count", log_val.size(), 32'd1);
        if (log_val.size() == 1) begin
            chk("post_rst_acc", log_val[0], 32'h00000006);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
